// File: rtl/morse_symbol_parser.sv
//============================================================================
// Module      : morse_symbol_parser
// Description : Classifies a raw Morse key into dot/dash symbol pulses and
//               letter/word gap pulses by timing mark and space lengths.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module morse_symbol_parser #(
  parameter int UNIT       = 4,    // clock cycles per Morse unit (>=1)
  parameter int CNT_W      = 10,   // width of mark/space counter
  parameter int MIN_MARK   = 1,    // marks shorter than this are glitches
  parameter bit ACTIVE_LOW = 1'b1  // 1: key pressed when input is low
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             unparsed,
  output logic             dot,
  output logic             dash,
  output logic             letter_end,
  output logic             word_end,
  output logic [CNT_W-1:0] sym_len,
  output logic             busy
);

  // Legal parameter sets keep 7*UNIT within the counter range and
  // MIN_MARK no larger than the dot/dash threshold.

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LIMIT  = CNT_W'(2 * UNIT);
  localparam logic [CNT_W-1:0] LETTER_CNT = CNT_W'(3 * UNIT);
  localparam logic [CNT_W-1:0] WORD_CNT   = CNT_W'(7 * UNIT);
  localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_MARK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2
  } state_t;

  logic             pressed_raw;
  logic             sync1_q;
  logic             key_s_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic [CNT_W-1:0] sym_len_q;
  logic             dot_q;
  logic             dash_q;
  logic             letter_end_q;
  logic             word_end_q;
  logic             busy_q;

  // Normalise key polarity so that 1 always means pressed.
  assign pressed_raw = ACTIVE_LOW ? ~unparsed : unparsed;

  // Saturating increment: long marks pin at the counter maximum instead of wrapping.
  assign cnt_inc_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Two-flop synchronizer for the asynchronous key; reset forces "released".
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      sync1_q <= pressed_raw;
      key_s_q <= sync1_q;
    end
  end

  // Mark/space timing FSM with registered, single-cycle event outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sym_len_q    <= '0;
      dot_q        <= 1'b0;
      dash_q       <= 1'b0;
      letter_end_q <= 1'b0;
      word_end_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      dot_q        <= 1'b0;
      dash_q       <= 1'b0;
      letter_end_q <= 1'b0;
      word_end_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_s_q) begin
            state_q <= S_MARK;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        S_MARK: begin
          if (key_s_q) begin
            cnt_q <= cnt_inc_d;
          end else begin
            // Glitches shorter than MIN_MARK still start a space interval.
            if (cnt_q >= MIN_CNT) begin
              if (cnt_q < DOT_LIMIT) begin
                dot_q <= 1'b1;
              end else begin
                dash_q <= 1'b1;
              end
              sym_len_q <= cnt_q;
            end
            state_q <= S_SPACE;
            cnt_q   <= CNT_ONE;
          end
        end
        S_SPACE: begin
          if (key_s_q) begin
            state_q <= S_MARK;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= cnt_inc_d;
            // Equality tests make each gap pulse fire once per interval.
            if (cnt_inc_d == LETTER_CNT) begin
              letter_end_q <= 1'b1;
            end
            if (cnt_inc_d == WORD_CNT) begin
              word_end_q <= 1'b1;
              state_q    <= S_IDLE;
              cnt_q      <= '0;
              busy_q     <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dot        = dot_q;
  assign dash       = dash_q;
  assign letter_end = letter_end_q;
  assign word_end   = word_end_q;
  assign sym_len    = sym_len_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_morse_symbol_parser.sv
//============================================================================
// Module      : tb_morse_symbol_parser
// Description : Scoreboard bench for morse_symbol_parser. Three instances:
//               defaults, MIN_MARK=2, and ACTIVE_LOW=0 on an inverted key.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_morse_symbol_parser;

  localparam int UNIT   = 4;
  localparam int CNT_W  = 10;
  localparam int SAT    = (1 << CNT_W) - 1;
  localparam int K_DOT  = 0;
  localparam int K_DASH = 1;
  localparam int K_LET  = 2;
  localparam int K_WORD = 3;

  typedef struct {
    int edge_n;
    int kind;
    int len;
  } ev_t;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             unparsed = 1'b1;
  logic             unparsed_n;
  logic             dot_o  [3];
  logic             dash_o [3];
  logic             le_o   [3];
  logic             we_o   [3];
  logic [CNT_W-1:0] sl_o   [3];
  logic             busy_o [3];

  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   mm [3] = '{1, 2, 1};
  int   last_len [3] = '{0, 0, 0};
  bit   after_press = 1'b0;
  ev_t  q0[$];
  ev_t  q1[$];
  ev_t  q2[$];

  assign unparsed_n = ~unparsed;

  always #5 Clock = ~Clock;

  // Edge counter: value seen after edge N (until the next edge) is N.
  always @(posedge Clock) edge_cnt <= edge_cnt + 1;

  morse_symbol_parser #(.UNIT(UNIT), .CNT_W(CNT_W), .MIN_MARK(1), .ACTIVE_LOW(1)) u0 (
    .Clock(Clock), .Reset(Reset), .unparsed(unparsed),
    .dot(dot_o[0]), .dash(dash_o[0]), .letter_end(le_o[0]), .word_end(we_o[0]),
    .sym_len(sl_o[0]), .busy(busy_o[0]));

  morse_symbol_parser #(.UNIT(UNIT), .CNT_W(CNT_W), .MIN_MARK(2), .ACTIVE_LOW(1)) u1 (
    .Clock(Clock), .Reset(Reset), .unparsed(unparsed),
    .dot(dot_o[1]), .dash(dash_o[1]), .letter_end(le_o[1]), .word_end(we_o[1]),
    .sym_len(sl_o[1]), .busy(busy_o[1]));

  morse_symbol_parser #(.UNIT(UNIT), .CNT_W(CNT_W), .MIN_MARK(1), .ACTIVE_LOW(0)) u2 (
    .Clock(Clock), .Reset(Reset), .unparsed(unparsed_n),
    .dot(dot_o[2]), .dash(dash_o[2]), .letter_end(le_o[2]), .word_end(we_o[2]),
    .sym_len(sl_o[2]), .busy(busy_o[2]));

  // ---------------- queue helpers ----------------
  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ev_t qfront(input int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    case (i)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic push_ev(input int i, input int e, input int k, input int l);
    ev_t ev;
    ev.edge_n = e;
    ev.kind   = k;
    ev.len    = l;
    case (i)
      0: q0.push_back(ev);
      1: q1.push_back(ev);
      default: q2.push_back(ev);
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // ---------------- reference model + driver ----------------
  // A key press of n raw samples is released at raw edge r; the symbol appears
  // two edges later. Space count is 1 at r+2, so count k lands on edge r+k+1.
  task automatic drive_press(input int n);
    int r;
    int len;
    r   = edge_cnt + 1 + n;
    len = (n > SAT) ? SAT : n;
    for (int i = 0; i < 3; i++) begin
      if (n >= mm[i]) begin
        push_ev(i, r + 2, (len < 2 * UNIT) ? K_DOT : K_DASH, len);
        last_len[i] = len;
      end
    end
    unparsed = 1'b0;
    repeat (n) tick();
    after_press = 1'b1;
    if (n >= 3) chk("busy_in_mark", int'(busy_o[0]), 1);
  endtask

  task automatic drive_release(input int g);
    int  r;
    bit  had_press;
    r = edge_cnt + 1;
    had_press = after_press;
    if (had_press) begin
      for (int i = 0; i < 3; i++) begin
        if (g >= 3 * UNIT) push_ev(i, r + 3 * UNIT + 1, K_LET, 0);
        if (g >= 7 * UNIT) push_ev(i, r + 7 * UNIT + 1, K_WORD, 0);
      end
    end
    unparsed = 1'b1;
    repeat (g) tick();
    if (g >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("sym_len_inst%0d", i), int'(sl_o[i]), last_len[i]);
        chk($sformatf("busy_inst%0d", i), int'(busy_o[i]),
            (had_press && g < 7 * UNIT + 2) ? 1 : 0);
      end
    end
    if (g >= 7 * UNIT) after_press = 1'b0;
  endtask

  task automatic reset_mid_press(input int n);
    unparsed = 1'b0;
    repeat (n) tick();
    Reset    = 1'b1;
    unparsed = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      last_len[i] = 0;
      chk($sformatf("busy_after_reset_inst%0d", i), int'(busy_o[i]), 0);
      chk($sformatf("sym_len_after_reset_inst%0d", i), int'(sl_o[i]), 0);
    end
    after_press = 1'b0;
    tick();
    chk("busy_cycle_after_reset", int'(busy_o[0]), 0);
  endtask

  // ---------------- monitor ----------------
  task automatic mon_inst(input int i);
    int  np;
    int  kind;
    ev_t e;
    while (qsize(i) > 0) begin
      e = qfront(i);
      if (e.edge_n >= edge_cnt) break;
      checks++;
      errors++;
      $display("FAIL missed_event inst%0d: kind %0d expected at edge %0d, not observed by edge %0d",
               i, e.kind, e.edge_n, edge_cnt);
      qpop(i);
    end
    np = $countones({dot_o[i], dash_o[i], le_o[i], we_o[i]});
    if (np != 0) begin
      kind = dot_o[i] ? K_DOT : dash_o[i] ? K_DASH : le_o[i] ? K_LET : K_WORD;
      if (np > 1) begin
        checks++;
        errors++;
        $display("FAIL exclusive inst%0d: %0d pulses high at edge %0d, expected 1", i, np, edge_cnt);
      end
      checks++;
      if (qsize(i) == 0) begin
        errors++;
        $display("FAIL unexpected inst%0d: kind %0d at edge %0d, expected no pulse", i, kind, edge_cnt);
      end else begin
        e = qfront(i);
        if (e.edge_n != edge_cnt) begin
          errors++;
          $display("FAIL unexpected inst%0d: kind %0d at edge %0d, next expected kind %0d at edge %0d",
                   i, kind, edge_cnt, e.kind, e.edge_n);
        end else begin
          qpop(i);
          if (kind != e.kind) begin
            errors++;
            $display("FAIL kind inst%0d: got %0d, expected %0d at edge %0d", i, kind, e.kind, edge_cnt);
          end else if (kind <= K_DASH && int'(sl_o[i]) != e.len) begin
            errors++;
            $display("FAIL sym_len inst%0d: got %0d, expected %0d", i, sl_o[i], e.len);
          end
        end
      end
    end
  endtask

  always @(negedge Clock) begin
    for (int i = 0; i < 3; i++) mon_inst(i);
  end

  // ---------------- stimulus ----------------
  initial begin
    int gb [7] = '{11, 12, 13, 27, 28, 29, 30};
    int g;
    Reset    = 1'b1;
    unparsed = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy_inst%0d", i), int'(busy_o[i]), 0);
      chk($sformatf("reset_sym_len_inst%0d", i), int'(sl_o[i]), 0);
      chk($sformatf("reset_pulses_inst%0d", i),
          $countones({dot_o[i], dash_o[i], le_o[i], we_o[i]}), 0);
    end
    Reset = 1'b0;
    drive_release(5);

    // Directed: basic dot, dot/dash boundary, gap timing, glitch, saturation.
    drive_press(4);    drive_release(40);
    drive_press(7);    drive_release(40);
    drive_press(8);    drive_release(40);
    drive_press(4);    drive_release(11);
    drive_press(4);    drive_release(20);
    drive_press(3);    drive_release(40);
    drive_press(1);    drive_release(40);
    drive_press(1100); drive_release(40);
    reset_mid_press(6);
    drive_release(10);

    // Randomized mark/space sequences with a bias toward gap boundaries.
    for (int n = 0; n < 60; n++) begin
      drive_press($urandom_range(1, 12));
      if ($urandom_range(0, 3) == 0) g = gb[$urandom_range(0, 6)];
      else g = $urandom_range(1, 35);
      drive_release(g);
    end
    drive_press(5);
    drive_release(40);
    repeat (2) tick();

    chk("queue_empty_inst0", q0.size(), 0);
    chk("queue_empty_inst1", q1.size(), 0);
    chk("queue_empty_inst2", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
